hazard_ctrl_mt: RTL and testbench

HAZARD_CTRL_MT -- requirements
Module: hazard_ctrl_mt

---
 rtl/hazard_ctrl_mt.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl_mt.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mt.sv
// Multithreaded pipeline hazard controller: forwarding, load-use stall, branch flush, memory wait.
// Optional macro HAZ_PERF_CNT_EN adds a saturating stall-cycle performance counter.
//
// state    | meaning
// RUN      | normal issue; load-use stalls, branch flushes, deferred flush replay
// MEM_WAIT | memory not ready; whole pipe held, branch flush deferred until RUN
module hazard_ctrl_mt #(
    parameter int BITS_THREADS = 3,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4:0]              rs1_d,
    input  logic [4:0]              rs2_d,
    input  logic [BITS_THREADS-1:0] tid_d,
    input  logic [4:0]              rs1_e,
    input  logic [4:0]              rs2_e,
    input  logic [4:0]              rd_e,
    input  logic [BITS_THREADS-1:0] tid_e,
    input  logic [1:0]              res_src_e,
    input  logic                    pc_src_e,
    input  logic [4:0]              rd_m,
    input  logic [BITS_THREADS-1:0] tid_m,
    input  logic                    reg_write_m,
    input  logic                    mem_req_m,
    input  logic                    mem_ready_m,
    input  logic [4:0]              rd_w,
    input  logic [BITS_THREADS-1:0] tid_w,
    input  logic                    reg_write_w,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic                    stall_e,
    output logic                    stall_m,
    output logic                    flush_d,
    output logic                    flush_e,
    output logic [1:0]              forward_a_e,
    output logic [1:0]              forward_b_e,
    output logic                    mem_err,
    output logic [31:0]             stall_cycles
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state, state_next;
    logic       pending_flush, pending_flush_next;
    logic [7:0] wait_cnt, wait_cnt_next, wait_cnt_inc;
    logic       mem_err_next;
    logic       m_ok, w_ok, load_use;

    assign m_ok     = reg_write_m && (rd_m != 5'd0) && (tid_m == tid_e);
    assign w_ok     = reg_write_w && (rd_w != 5'd0) && (tid_w == tid_e);
    assign load_use = (res_src_e == 2'b01) && (rd_e != 5'd0) && (tid_e == tid_d) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign wait_cnt_inc = wait_cnt + 8'd1;

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (!clr) begin
            if (m_ok && (rd_m == rs1_e))      forward_a_e = 2'b10;
            else if (w_ok && (rd_w == rs1_e)) forward_a_e = 2'b01;
            if (m_ok && (rd_m == rs2_e))      forward_b_e = 2'b10;
            else if (w_ok && (rd_w == rs2_e)) forward_b_e = 2'b01;
        end
    end

    always_comb begin
        state_next         = state;
        pending_flush_next = pending_flush;
        wait_cnt_next      = wait_cnt;
        mem_err_next       = 1'b0;
        stall_f            = 1'b0;
        stall_d            = 1'b0;
        stall_e            = 1'b0;
        stall_m            = 1'b0;
        flush_d            = 1'b0;
        flush_e            = 1'b0;
        if (!clr) begin
            case (state)
                RUN: begin
                    wait_cnt_next = 8'd0;
                    if (mem_req_m && !mem_ready_m) begin
                        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                        pending_flush_next = pending_flush | pc_src_e;
                        state_next         = MEM_WAIT;
                    end else begin
                        pending_flush_next = 1'b0;
                        if (load_use) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            flush_e = 1'b1;
                        end
                        if (pc_src_e || pending_flush) begin
                            flush_d = 1'b1;
                            flush_e = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    pending_flush_next = pending_flush | pc_src_e;
                    if (mem_ready_m) begin
                        state_next    = RUN;
                        wait_cnt_next = 8'd0;
                    end else begin
                        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                        // The cycle that brings the count to the limit is the last wait cycle.
                        if (wait_cnt_inc >= TIMEOUT_CNT) begin
                            state_next    = RUN;
                            wait_cnt_next = 8'd0;
                            mem_err_next  = 1'b1;
                        end else begin
                            wait_cnt_next = wait_cnt_inc;
                        end
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= RUN;
            pending_flush <= 1'b0;
            wait_cnt      <= 8'd0;
            mem_err       <= 1'b0;
        end else begin
            state         <= state_next;
            pending_flush <= pending_flush_next;
            wait_cnt      <= wait_cnt_next;
            mem_err       <= mem_err_next;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (clr)
            stall_cnt <= 32'd0;
        else if (stall_d && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mt.sv
// Scoreboard bench for hazard_ctrl_mt: one default instance and one with a short memory timeout.
module tb_hazard_ctrl_mt;
    localparam int BT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [BT-1:0] tid_d, tid_e, tid_m, tid_w;
    logic [1:0]    res_src_e;
    logic          pc_src_e, reg_write_m, mem_req_m, mem_ready_m, reg_write_w;

    logic        m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_err;
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_cyc;
    logic        t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_err;
    logic [1:0]  t_fa, t_fb;
    logic [31:0] t_cyc;

    hazard_ctrl_mt #(.BITS_THREADS(BT)) dut (
        .clk(clk), .clr(clr), .rs1_d(rs1_d), .rs2_d(rs2_d), .tid_d(tid_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .tid_e(tid_e), .res_src_e(res_src_e),
        .pc_src_e(pc_src_e), .rd_m(rd_m), .tid_m(tid_m), .reg_write_m(reg_write_m),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m), .rd_w(rd_w), .tid_w(tid_w),
        .reg_write_w(reg_write_w), .stall_f(m_sf), .stall_d(m_sd), .stall_e(m_se),
        .stall_m(m_sm), .flush_d(m_fd), .flush_e(m_fe), .forward_a_e(m_fa),
        .forward_b_e(m_fb), .mem_err(m_err), .stall_cycles(m_cyc));

    hazard_ctrl_mt #(.BITS_THREADS(BT), .MEM_TIMEOUT(3)) dut_to (
        .clk(clk), .clr(clr), .rs1_d(rs1_d), .rs2_d(rs2_d), .tid_d(tid_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .tid_e(tid_e), .res_src_e(res_src_e),
        .pc_src_e(pc_src_e), .rd_m(rd_m), .tid_m(tid_m), .reg_write_m(reg_write_m),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m), .rd_w(rd_w), .tid_w(tid_w),
        .reg_write_w(reg_write_w), .stall_f(t_sf), .stall_d(t_sd), .stall_e(t_se),
        .stall_m(t_sm), .flush_d(t_fd), .flush_e(t_fe), .forward_a_e(t_fa),
        .forward_b_e(t_fb), .mem_err(t_err), .stall_cycles(t_cyc));

    // Observation layout: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a, fwd_b, mem_err}
    logic [10:0] obs_m, obs_t, obs;
    assign obs_m = {m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_fa, m_fb, m_err};
    assign obs_t = {t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_fa, t_fb, t_err};

    localparam logic [10:0] E_ZERO = 11'b0000_00_00_00_0;
    localparam logic [10:0] E_MEM  = 11'b1111_00_00_00_0;
    localparam logic [10:0] E_LU   = 11'b1100_01_00_00_0;
    localparam logic [10:0] E_BR   = 11'b0000_11_00_00_0;
    localparam logic [10:0] E_LUBR = 11'b1100_11_00_00_0;
    localparam logic [10:0] E_ERR  = 11'b0000_00_00_00_1;

    typedef struct {
        string       name;
        bit          to;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [10:0] e_fwd(input logic [1:0] fa, input logic [1:0] fb);
        return {6'b0, fa, fb, 1'b0};
    endfunction

    task automatic push(input string name, input bit to, input logic [10:0] v);
        exp_t x;
        x.name = name;
        x.to   = to;
        x.v    = v;
        sb.push_back(x);
    endtask

    task automatic clear_inputs();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {tid_d, tid_e, tid_m, tid_w} = '0;
        res_src_e = 2'b00;
        {pc_src_e, reg_write_m, mem_req_m, mem_ready_m, reg_write_w} = '0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        res_src_e = 2'b01; rd_e = 5'd5; rs1_d = 5'd5; pc_src_e = 1'b1; mem_req_m = 1'b1;
        rs1_e = 5'd7; rd_m = 5'd7; reg_write_m = 1'b1;
        @(posedge clk); #1;
        push("reset_main", 1'b0, E_ZERO);
        push("reset_to", 1'b1, E_ZERO);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
        end
        checks++;
        if (m_cyc !== 32'd0) begin failures++; $display("FAIL reset_stall_cycles: got %0d expected 0", m_cyc); end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin res_src_e = 2'b01; rd_e = 5'd5; tid_e = 3'd2; tid_d = 3'd2; rs1_d = 5'd5; push("lu_rs1", 0, E_LU); end
                1: begin tid_d = 3'd3; push("lu_other_thread", 0, E_ZERO); end
                2: begin tid_d = 3'd2; rs1_d = 5'd0; rs2_d = 5'd5; push("lu_rs2", 0, E_LU); end
                3: begin rd_e = 5'd0; rs2_d = 5'd0; push("lu_rd_zero", 0, E_ZERO); end
                default: begin rd_e = 5'd5; rs2_d = 5'd5; res_src_e = 2'b00; push("lu_not_load", 0, E_ZERO); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin pc_src_e = 1'b1; push("br_flush", 0, E_BR); end
                1: begin res_src_e = 2'b01; rd_e = 5'd9; rs2_d = 5'd9; push("br_and_lu", 0, E_LUBR); end
                default: begin clear_inputs(); push("br_idle", 0, E_ZERO); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin
                    tid_e = 3'd1; tid_m = 3'd1; tid_w = 3'd1; rs1_e = 5'd7; rs2_e = 5'd7;
                    rd_m = 5'd7; rd_w = 5'd7; reg_write_m = 1'b1; reg_write_w = 1'b1;
                    push("fwd_m_priority", 0, e_fwd(2'b10, 2'b10));
                end
                1: begin reg_write_m = 1'b0; push("fwd_w_only", 0, e_fwd(2'b01, 2'b01)); end
                2: begin reg_write_m = 1'b1; rd_m = 5'd0; rd_w = 5'd0; push("fwd_rd_zero", 0, e_fwd(2'b00, 2'b00)); end
                3: begin rs1_e = 5'd0; rs2_e = 5'd0; push("fwd_x0_match", 0, e_fwd(2'b00, 2'b00)); end
                4: begin rd_m = 5'd7; rd_w = 5'd3; rs1_e = 5'd7; rs2_e = 5'd3; push("fwd_split", 0, e_fwd(2'b10, 2'b01)); end
                5: begin rd_w = 5'd7; rs2_e = 5'd7; tid_m = 3'd2; tid_w = 3'd2; push("fwd_other_thread", 0, e_fwd(2'b00, 2'b00)); end
                default: begin tid_w = 3'd1; push("fwd_m_other_w_same", 0, e_fwd(2'b01, 2'b01)); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [31:0] exp_cyc;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin mem_req_m = 1'b1; mem_ready_m = 1'b0; push("mw_entry", 0, E_MEM); end
                1: push("mw_wait1", 0, E_MEM);
                2: begin rs1_e = 5'd7; rd_m = 5'd7; reg_write_m = 1'b1; push("mw_wait2_fwd", 0, E_MEM | e_fwd(2'b10, 2'b00)); end
                3: begin reg_write_m = 1'b0; push("mw_wait3", 0, E_MEM); end
                4: begin mem_ready_m = 1'b1; push("mw_ready", 0, E_ZERO); end
                default: begin clear_inputs(); push("mw_after", 0, E_ZERO); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
`ifdef HAZ_PERF_CNT_EN
        exp_cyc = 32'd4;
`else
        exp_cyc = 32'd0;
`endif
        checks++;
        if (m_cyc !== exp_cyc) begin failures++; $display("FAIL mw_stall_cycles: got %0d expected %0d", m_cyc, exp_cyc); end
    endtask

    task automatic test_deferred_flush();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin mem_req_m = 1'b1; push("df_entry", 0, E_MEM); end
                1: push("df_wait1", 0, E_MEM);
                2: begin pc_src_e = 1'b1; push("df_wait2_branch", 0, E_MEM); end
                3: begin pc_src_e = 1'b0; push("df_wait3", 0, E_MEM); end
                4: begin mem_ready_m = 1'b1; push("df_ready", 0, E_ZERO); end
                5: begin clear_inputs(); push("df_first_run", 0, E_BR); end
                default: push("df_cleared", 0, E_ZERO);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin mem_req_m = 1'b1; push("to_entry", 1, E_MEM); end
                1: push("to_wait1", 1, E_MEM);
                2: push("to_wait2", 1, E_MEM);
                3: push("to_wait3", 1, E_MEM);
                4: begin mem_req_m = 1'b0; push("to_err_pulse", 1, E_ERR); end
                default: push("to_err_clear", 1, E_ZERO);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin mem_req_m = 1'b1; push("rmw_entry", 0, E_MEM); end
                1: begin pc_src_e = 1'b1; push("rmw_wait1_branch", 0, E_MEM); end
                2: begin
                    clr = 1'b1; rs1_e = 5'd4; rd_m = 5'd4; reg_write_m = 1'b1;
                    push("rmw_clr", 0, E_ZERO);
                end
                3: begin clr = 1'b0; clear_inputs(); push("rmw_no_flush", 0, E_ZERO); end
                default: push("rmw_idle", 0, E_ZERO);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            if (i == 3) begin
                checks++;
                if (m_cyc !== 32'd0) begin failures++; $display("FAIL rmw_stall_cycles: got %0d expected 0", m_cyc); end
            end
            @(posedge clk); #1;
        end
        // Reset landing on the timeout cycle must swallow the error pulse.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin mem_req_m = 1'b1; push("rto_entry", 1, E_MEM); end
                1: begin pc_src_e = 1'b1; push("rto_wait1", 1, E_MEM); end
                2: begin pc_src_e = 1'b0; push("rto_wait2", 1, E_MEM); end
                3: begin clr = 1'b1; push("rto_clr_on_timeout", 1, E_ZERO); end
                4: begin clr = 1'b0; clear_inputs(); push("rto_no_err", 1, E_ZERO); end
                default: push("rto_idle", 1, E_ZERO);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            obs = e.to ? obs_t : obs_m;
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clr = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_forward();
        test_mem_wait();
        test_deferred_flush();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
